// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor: requests configuration, waits for a debounced lock-detect, retries with holdoff.
// Optional macro PLL_LD_SYNC_EN adds a two-flop synchronizer on in_ld.
module pll_lock_monitor #(
  parameter int unsigned P_DEBOUNCE     = 16,
  parameter int unsigned P_LOCK_TIMEOUT = 1000000,
  parameter int unsigned P_MAX_RETRY    = 4,
  parameter int unsigned P_HOLDOFF      = 1024
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_ld,
  input  logic       in_cfg_done,
  input  logic       in_clear,
  output logic       out_cfg_start,
  output logic       out_locked,
  output logic       out_lock_lost,
  output logic       out_fail,
  output logic [7:0] out_retry_cnt
);

  localparam logic [7:0]  DEB_LAST  = 8'(P_DEBOUNCE - 1);
  localparam logic [7:0]  MAX_RETRY = 8'(P_MAX_RETRY);
  localparam logic [31:0] TMO_LOAD  = (P_LOCK_TIMEOUT == 0) ? 32'd0 : 32'(P_LOCK_TIMEOUT - 1);
  localparam logic [31:0] HOLD_LOAD = (P_HOLDOFF == 0) ? 32'd0 : 32'(P_HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CFG, S_WAIT_LOCK, S_LOCKED, S_HOLDOFF, S_FAIL
  } state_t;

  logic ld_s;

`ifdef PLL_LD_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge in_clk) begin
    if (in_rst) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], in_ld};
  end
  assign ld_s = sync_q[1];
`else
  assign ld_s = in_ld;
`endif

  logic       ld_filt_q, ld_filt_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;

  // Filtered value flips on the P_DEBOUNCE-th consecutive differing sample.
  always_comb begin
    ld_filt_d = ld_filt_q;
    deb_cnt_d = 8'd0;
    if (ld_s != ld_filt_q) begin
      if (deb_cnt_q == DEB_LAST) ld_filt_d = ~ld_filt_q;
      else                       deb_cnt_d = deb_cnt_q + 8'd1;
    end
  end

  state_t      state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  retry_q, retry_d;
  logic        lost_q, lost_d;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (in_clear) lost_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        retry_d = 8'd0;
        state_d = S_START;
      end
      S_START: state_d = S_WAIT_CFG;
      S_WAIT_CFG: begin
        if (in_cfg_done) begin
          tmo_d   = TMO_LOAD;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (ld_filt_q) begin
          state_d = S_LOCKED;
        end else if (tmo_q == 32'd0) begin
          if (retry_q >= MAX_RETRY) begin
            state_d = S_FAIL;
          end else begin
            hold_d  = HOLD_LOAD;
            state_d = S_HOLDOFF;
          end
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end
      S_LOCKED: begin
        // Lock-loss set overrides a simultaneous clear.
        if (!ld_filt_q) begin
          lost_d  = 1'b1;
          retry_d = 8'd0;
          hold_d  = HOLD_LOAD;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == 32'd0) state_d = S_START;
        else                 hold_d  = hold_q - 32'd1;
      end
      S_FAIL: begin
        if (in_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Count the attempt on entry so the count is visible alongside the start pulse.
    if (state_d == S_START && state_q != S_START)
      retry_d = (retry_d == 8'hFF) ? 8'hFF : retry_d + 8'd1;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= S_IDLE;
      ld_filt_q <= 1'b0;
      deb_cnt_q <= 8'd0;
      tmo_q     <= 32'd0;
      hold_q    <= 32'd0;
      retry_q   <= 8'd0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_filt_q <= ld_filt_d;
      deb_cnt_q <= deb_cnt_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
    end
  end

  assign out_cfg_start = (state_q == S_START);
  assign out_locked    = (state_q == S_LOCKED);
  assign out_fail      = (state_q == S_FAIL);
  assign out_lock_lost = lost_q;
  assign out_retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: vector table for reset/startup, hand sequences for lock, loss, retry, fail.
module tb_pll_lock_monitor;

  localparam int DEB   = 4;
  localparam int TMO   = 100;
  localparam int RETRY = 3;
  localparam int HOLD  = 10;
`ifdef PLL_LD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LOCK_LAT = DEB + SYNC_LAT + 1;
  // START (1) + WAIT_CFG answered next cycle (1) + timeout + holdoff
  localparam int SPACING  = 2 + TMO + HOLD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic       cfg_done = 1'b0;
  logic       clear = 1'b0;
  logic       cfg_start, locked, lost, fail;
  logic [7:0] retry;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .P_DEBOUNCE(DEB), .P_LOCK_TIMEOUT(TMO), .P_MAX_RETRY(RETRY), .P_HOLDOFF(HOLD)
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_ld(ld), .in_cfg_done(cfg_done), .in_clear(clear),
    .out_cfg_start(cfg_start), .out_locked(locked), .out_lock_lost(lost),
    .out_fail(fail), .out_retry_cnt(retry)
  );

  // exp packs {cfg_start, locked, lock_lost, fail, retry_cnt[7:0]}
  typedef struct {
    logic        rst;
    logic        cfg_done;
    logic        clear;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [11:0] outs();
    return {cfg_start, locked, lost, fail, retry};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got 'h%0h ok", name, act);
    end else begin
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_start && n < 2000);
    check({name, "_seen"}, {31'd0, cfg_start}, 32'd1);
  endtask

  // Called with cfg_start visible; done is presented while in WAIT_CFG.
  task automatic answer_cfg();
    tick();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    int starts;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 12'h801};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 12'h001};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 12'h001};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 12'h001};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 12'h001};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 12'h001};

    for (int i = 0; i < 8; i++) begin
      rst      = vecs[i].rst;
      cfg_done = vecs[i].cfg_done;
      clear    = vecs[i].clear;
      tick();
      check($sformatf("vec%0d", i), {20'd0, outs()}, {20'd0, vecs[i].exp});
    end
    cfg_done = 1'b0;
    clear    = 1'b0;

    // Basic lock latency
    ld = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!locked && n < 50);
    check("lock_latency", n, LOCK_LAT);

    // Three-cycle glitch must not disturb lock
    bad = 0;
    ld = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 2) ld = 1'b1;
      if (!locked || lost) bad++;
    end
    check("glitch_rejected", bad, 0);

    // Lock loss coinciding with clear: set must win
    ld = 1'b0;
    repeat (DEB + SYNC_LAT) tick();
    check("locked_before_loss", {31'd0, locked}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("unlocked_after_loss", {31'd0, locked}, 32'd0);
    check("lost_set_wins", {31'd0, lost}, 32'd1);
    check("retry_cleared_on_loss", {24'd0, retry}, 32'd0);

    wait_start("holdoff_start", n);
    check("holdoff_len", n, HOLD);
    check("retry_after_holdoff", {24'd0, retry}, 32'd1);
    check("lost_sticky", {31'd0, lost}, 32'd1);

    // Timeout retries with LD held low
    for (int a = 2; a <= RETRY; a++) begin
      answer_cfg();
      wait_start($sformatf("retry%0d", a), n);
      check($sformatf("retry_spacing_%0d", a), n + 2, SPACING);
      check($sformatf("retry_cnt_%0d", a), {24'd0, retry}, a);
    end
    answer_cfg();
    n = 0;
    do begin
      tick();
      n++;
    end while (!fail && n < 2000);
    check("fail_after_timeout", n + 2, 2 + TMO);
    check("fail_retry_cnt", {24'd0, retry}, RETRY);
    check("lost_sticky_in_fail", {31'd0, lost}, 32'd1);

    starts = 0;
    bad = 0;
    repeat (200) begin
      tick();
      if (cfg_start) starts++;
      if (!fail) bad++;
    end
    check("no_start_in_fail", starts, 0);
    check("fail_held", bad, 0);

    // Recovery via clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("fail_cleared", {31'd0, fail}, 32'd0);
    check("lost_cleared", {31'd0, lost}, 32'd0);
    tick();
    check("restart_pulse", {31'd0, cfg_start}, 32'd1);
    check("restart_retry", {24'd0, retry}, 32'd1);
    tick();
    check("start_one_cycle", {31'd0, cfg_start}, 32'd0);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;

    // Reset in WAIT_LOCK
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_outputs", {20'd0, outs()}, 32'h000);
    tick();
    check("post_reset_start", {20'd0, outs()}, 32'h801);

    // Reset while the start pulse is pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pending_start_dropped", {20'd0, outs()}, 32'h000);
    tick();
    check("fresh_start_after_reset", {20'd0, outs()}, 32'h801);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
